expr_stream_eval: RTL

//  Parametrised, pipelined evaluator for mixed signed/unsigned expressions.

---
 rtl/expr_eval_pkg.sv | 36 +++
 rtl/expr_eval_lane.sv | 70 +++++++
 rtl/expr_stream_eval.sv | 121 ++++++++++++
 3 files changed

// File: rtl/expr_eval_pkg.sv
// Shared opcode encoding and width helpers for the expression stream evaluator.
// CEQ is an alias of EQ: the 4-bit space holds exactly sixteen distinct operations.
package expr_eval_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_XNOR = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ASHR = 4'h8,
        OP_EQ   = 4'h9,
        OP_NE   = 4'hA,
        OP_LT   = 4'hB,
        OP_GE   = 4'hC,
        OP_RAND = 4'hD,
        OP_RXOR = 4'hE,
        OP_ACC  = 4'hF
    } op_e;

    // Case equality is indistinguishable from EQ on 2-state lane data.
    localparam op_e OP_CEQ = OP_EQ;

    // Arithmetic is evaluated one bit wider than the lane to expose carry/overflow.
    function automatic int unsigned ext_width(input int unsigned w);
        return w + 1;
    endfunction

    function automatic int unsigned bus_width(input int unsigned nch, input int unsigned w);
        return nch * w;
    endfunction

endpackage

// File: rtl/expr_eval_lane.sv
// Combinational datapath for one lane: operands are sign- or zero-extended by sgn,
// then the selected operation produces a W-bit result and an overflow/carry flag.
module expr_eval_lane
    import expr_eval_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  op_e          op,
    input  logic         sgn,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] acc,
    output logic [W-1:0] y,
    output logic         ovf
);

    localparam int unsigned  XW   = ext_width(W);
    localparam logic [W-1:0] WMAX = W'(W);

    logic [XW-1:0] ax, bx, cx;
    logic [XW-1:0] sum, dif, asum;
    logic          big_shift, lt, eq;

    always_comb begin
        ax        = {sgn & a[W-1], a};
        bx        = {sgn & b[W-1], b};
        cx        = {sgn & acc[W-1], acc};
        sum       = ax + bx;
        dif       = ax - bx;
        asum      = cx + ax;
        big_shift = (b >= WMAX);
        lt        = $signed(ax) < $signed(bx);
        eq        = (a == b);
        y         = '0;
        ovf       = 1'b0;
        // Signed overflow shows as disagreement of the two top bits of the extended result.
        unique case (op)
            OP_ADD: begin
                y   = sum[W-1:0];
                ovf = sgn ? (sum[W] ^ sum[W-1]) : sum[W];
            end
            OP_SUB: begin
                y   = dif[W-1:0];
                ovf = sgn ? (dif[W] ^ dif[W-1]) : dif[W];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_SHL:  y = big_shift ? '0 : (a << b);
            OP_SHR:  y = big_shift ? '0 : (a >> b);
            OP_ASHR: begin
                if (sgn) y = big_shift ? {W{a[W-1]}} : W'($signed(a) >>> b);
                else     y = big_shift ? '0 : (a >> b);
            end
            OP_EQ:   y = {{(W-1){1'b0}}, eq};
            OP_NE:   y = {{(W-1){1'b0}}, ~eq};
            OP_LT:   y = {{(W-1){1'b0}}, lt};
            OP_GE:   y = {{(W-1){1'b0}}, ~lt};
            OP_RAND: y = {{(W-1){1'b0}}, &a};
            OP_RXOR: y = {{(W-1){1'b0}}, ^a};
            OP_ACC: begin
                y   = asum[W-1:0];
                ovf = sgn ? (asum[W] ^ asum[W-1]) : asum[W];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/expr_stream_eval.sv
// Two-stage elastic pipeline: S1 captures the transaction, S2 holds lane results.
// Per-lane accumulators update as an ACC transaction moves from S1 into S2.
module expr_stream_eval
    import expr_eval_pkg::*;
#(
    parameter int unsigned W   = 6,
    parameter int unsigned NCH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [NCH-1:0]   in_sgn,
    input  logic [NCH*W-1:0] in_a,
    input  logic [NCH*W-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NCH*W-1:0] out_y,
    output logic [NCH-1:0]   out_ovf
);

    localparam int unsigned BW = bus_width(NCH, W);

    logic           s1_v_q, s1_v_d;
    op_e            s1_op_q, s1_op_d;
    logic [NCH-1:0] s1_sgn_q, s1_sgn_d;
    logic [BW-1:0]  s1_a_q, s1_a_d;
    logic [BW-1:0]  s1_b_q, s1_b_d;
    logic           s2_v_q, s2_v_d;
    logic [BW-1:0]  s2_y_q, s2_y_d;
    logic [NCH-1:0] s2_ovf_q, s2_ovf_d;
    logic [BW-1:0]  acc_q, acc_d;

    logic [BW-1:0]  lane_y;
    logic [NCH-1:0] lane_ovf;
    logic           s2_adv, s1_adv, accept;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        expr_eval_lane #(
            .W(W)
        ) u_lane (
            .op  (s1_op_q),
            .sgn (s1_sgn_q[k]),
            .a   (s1_a_q[k*W +: W]),
            .b   (s1_b_q[k*W +: W]),
            .acc (acc_q[k*W +: W]),
            .y   (lane_y[k*W +: W]),
            .ovf (lane_ovf[k])
        );
    end

    // in_ready depends only on stage state and out_ready, never on in_valid.
    always_comb begin
        s2_adv   = !s2_v_q || out_ready;
        s1_adv   = s1_v_q && s2_adv;
        in_ready = !s1_v_q || s2_adv;
        accept   = in_valid && in_ready;

        s1_v_d   = s1_v_q;
        s1_op_d  = s1_op_q;
        s1_sgn_d = s1_sgn_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s2_v_d   = s2_v_q;
        s2_y_d   = s2_y_q;
        s2_ovf_d = s2_ovf_q;
        acc_d    = acc_q;

        if (accept) begin
            s1_v_d   = 1'b1;
            s1_op_d  = op_e'(in_op);
            s1_sgn_d = in_sgn;
            s1_a_d   = in_a;
            s1_b_d   = in_b;
        end else if (s1_adv) begin
            s1_v_d = 1'b0;
        end

        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_y_d   = lane_y;
                s2_ovf_d = lane_ovf;
            end
        end

        if (s1_adv && (s1_op_q == OP_ACC)) begin
            acc_d = lane_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_op_q  <= OP_ADD;
            s1_sgn_q <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_v_q   <= 1'b0;
            s2_y_q   <= '0;
            s2_ovf_q <= '0;
            acc_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_op_q  <= s1_op_d;
            s1_sgn_q <= s1_sgn_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s2_v_q   <= s2_v_d;
            s2_y_q   <= s2_y_d;
            s2_ovf_q <= s2_ovf_d;
            acc_q    <= acc_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_y     = s2_y_q;
    assign out_ovf   = s2_ovf_q;

endmodule
